// File: rtl/reg_pkg.sv
// Shared width and reset-word definitions for the parallel-load storage register.
`timescale 1ns/1ps
package reg_pkg;

  localparam int REG_WIDTH = 32;

  // Bit 0 is the MSB across the whole register family.
  localparam logic [0:REG_WIDTH-1] REG_RESET_WORD = '0;

endpackage

// File: rtl/reg_32b_dff_sync.sv
// Single-bit D flip-flop with synchronous active-high reset to RST_BIT.
`timescale 1ns/1ps
module dff_sync #(
  parameter logic RST_BIT = 1'b0
) (
  output logic q,
  input  logic d,
  input  logic clk,
  input  logic res
);

  always_ff @(posedge clk) begin
    if (res) q <= RST_BIT;
    else     q <= d;
  end

endmodule

// File: rtl/reg_32b.sv
// Parallel-load register of WIDTH independent flip-flops, bit 0 = MSB.
`timescale 1ns/1ps
module reg_32b
  import reg_pkg::*;
#(
  parameter int                 WIDTH       = REG_WIDTH,
  parameter logic [0:WIDTH-1]   RESET_VALUE = REG_RESET_WORD
) (
  output logic [0:WIDTH-1] data_out,
  input  logic [0:WIDTH-1] data_in,
  input  logic             clk,
  input  logic             res
);

  // Each bit gets its own flop so bit i only ever sees data_in[i] and res.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sync #(
      .RST_BIT (RESET_VALUE[i])
    ) u_dff (
      .q   (data_out[i]),
      .d   (data_in[i]),
      .clk (clk),
      .res (res)
    );
  end

endmodule

// File: tb/tb_reg_32b.sv
// Directed bench for reg_32b: reset, load, mid-cycle changes, reset priority, bit order.
`timescale 1ns/1ps
module tb_reg_32b;

  logic        clk;
  logic        res;
  logic [0:31] data_in;
  logic [0:31] data_out;

  int checks = 0;
  int passed = 0;

  reg_32b dut (
    .data_out (data_out),
    .data_in  (data_in),
    .clk      (clk),
    .res      (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic at(input time t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string tag, input logic [0:31] obs, input logic [0:31] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  initial begin
    logic [0:31] exp_tbl [5];
    logic [0:31] walk;
    exp_tbl = '{32'd0, 32'd2, 32'd4, 32'd5, 32'd7};

    // Reset across the first edge (5 ns).
    res     = 1'b1;
    data_in = 32'h0000_0005;
    at(9);
    check("reset", data_out, 32'h0);

    // Load 3 at edge 15; the change at 9 must not show before it.
    res     = 1'b0;
    data_in = 32'h0000_0003;
    at(12);
    check("hold_before_edge", data_out, 32'h0);
    at(17);
    check("load", data_out, 32'h0000_0003);

    // Short reset pulse 22..24 ns, no edge covered.
    at(22);
    res = 1'b1;
    at(23);
    check("pulse_mid", data_out, 32'h0000_0003);
    at(24);
    res = 1'b0;
    at(27);
    check("pulse_after_edge", data_out, 32'h0000_0003);

    // data_in counts up every 6 ns from 30 ns; edges at 35..75.
    at(30);
    data_in = 32'd0;
    fork
      begin
        for (int k = 1; k <= 8; k++) begin
          #6 data_in = k;
        end
      end
      begin
        for (int e = 0; e < 5; e++) begin
          at(35 + 10 * e + 2);
          check("count_after_edge", data_out, exp_tbl[e]);
          at(35 + 10 * e + 8);
          check("count_before_edge", data_out, exp_tbl[e]);
        end
      end
    join

    // Reset priority over an all-ones input at edge 95, then load at 105.
    at(90);
    check("value_before_reset", data_out, 32'd8);
    res     = 1'b1;
    data_in = 32'hFFFF_FFFF;
    at(97);
    check("reset_priority", data_out, 32'h0);
    at(99);
    res = 1'b0;
    at(107);
    check("load_after_reset", data_out, 32'hFFFF_FFFF);

    // Bit order: MSB and LSB together, then a walking one.
    at(108);
    data_in = 32'h8000_0001;
    at(117);
    check("msb_lsb", data_out, 32'h8000_0001);
    for (int i = 0; i < 32; i++) begin
      at(118 + 10 * i);
      walk    = 32'h8000_0000 >> i;
      data_in = walk;
      at(127 + 10 * i);
      check($sformatf("walk_%0d", i), data_out, walk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
